ahb_mem_ctrl: RTL and testbench



---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_lane_merge.sv | 32 +++
 rtl/ahb_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_ahb_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-controller state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR   = 3'd3,
    ST_RMW1 = 3'd4,
    ST_RMW2 = 3'd5,
    ST_ERR1 = 3'd6,
    ST_ERR2 = 3'd7
  } ctrl_state_t;

endpackage

// File: rtl/ahb_lane_merge.sv
// Combinational little-endian lane merge: replaces the byte/half/word lanes
// selected by hsize and byte lane in the old word with the new word's lanes.
module ahb_lane_merge
  import ahb_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_word,
  input  logic [2:0]  i_hsize,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged
);

  logic [3:0] w_byte_en;

  always_comb begin
    w_byte_en = 4'b1111;
    case (i_hsize)
      HSIZE_BYTE: w_byte_en = 4'b0001 << i_lane;
      HSIZE_HALF: w_byte_en = i_lane[1] ? 4'b1100 : 4'b0011;
      default:    w_byte_en = 4'b1111;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
      assign o_merged[8*gi +: 8] = w_byte_en[gi] ? i_new_word[8*gi +: 8]
                                                 : i_old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/ahb_mem_ctrl.sv
// AHB-Lite slave sequencing a single-port word memory; sub-word writes become
// read-modify-write. Define AHB_MEM_CTRL_ERR_EN to ERROR misaligned/oversize accesses.
module ahb_mem_ctrl
  import ahb_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [31:0]       r_hrdata;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [2:0]        r_size;
  logic [1:0]        r_lane;

  logic              w_accept;
  logic              w_err;
  logic [2:0]        w_size_eff;
  logic [1:0]        w_lane_eff;
  logic [31:0]       w_merged;
  logic              w_unused;

  assign w_accept = hsel & htrans[1] & hready;
  assign w_unused = ^{haddr[31:MEM_AW+2], htrans[0]};

`ifdef AHB_MEM_CTRL_ERR_EN
  assign w_err = (hsize > HSIZE_WORD)
               | ((hsize == HSIZE_HALF) & haddr[0])
               | ((hsize == HSIZE_WORD) & (|haddr[1:0]));
  assign w_size_eff = hsize;
  assign w_lane_eff = haddr[1:0];
`else
  // Oversize collapses to word; misaligned halves/words are force-aligned.
  assign w_err      = 1'b0;
  assign w_size_eff = (hsize > HSIZE_WORD) ? HSIZE_WORD : hsize;
  assign w_lane_eff = (hsize == HSIZE_HALF) ? {haddr[1], 1'b0} : haddr[1:0];
`endif

  always_comb begin
    w_next_state = ST_IDLE;
    if (w_accept) begin
      if (w_err)                         w_next_state = ST_ERR1;
      else if (!hwrite)                  w_next_state = ST_RD1;
      else if (w_size_eff == HSIZE_WORD) w_next_state = ST_WR;
      else                               w_next_state = ST_RMW1;
    end
  end

  ahb_lane_merge u_lane_merge (
    .i_old_word (mem_rdata),
    .i_new_word (hwdata),
    .i_hsize    (r_size),
    .i_lane     (r_lane),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_size      <= HSIZE_WORD;
      r_lane      <= 2'd0;
    end else begin
      case (r_state)
        ST_RD1: begin
          r_hrdata    <= mem_rdata;
          r_mem_read  <= 1'b0;
          r_hreadyout <= 1'b1;
          r_state     <= ST_RD2;
        end
        ST_RMW1: begin
          r_mem_wdata <= w_merged;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_hreadyout <= 1'b1;
          r_state     <= ST_RMW2;
        end
        ST_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= ST_ERR2;
        end
        // IDLE and every final data-phase cycle (hreadyout=1) may accept.
        default: begin
          r_state     <= w_next_state;
          r_mem_read  <= (w_next_state == ST_RD1) | (w_next_state == ST_RMW1);
          r_mem_write <= (w_next_state == ST_WR);
          r_hresp     <= (w_next_state == ST_ERR1) ? HRESP_ERROR : HRESP_OKAY;
          r_hreadyout <= !((w_next_state == ST_RD1) | (w_next_state == ST_RMW1) |
                           (w_next_state == ST_ERR1));
          if (w_accept) begin
            r_mem_addr <= haddr[MEM_AW+1:2];
            r_size     <= w_size_eff;
            r_lane     <= w_lane_eff;
          end
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;
  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  // Full-word writes forward the data-phase hwdata straight to the memory.
  assign mem_wdata = (r_state == ST_WR) ? hwdata : r_mem_wdata;

endmodule

// File: tb/tb_ahb_mem_ctrl.sv
// Directed self-checking bench for ahb_mem_ctrl with a behavioural 1024x32 memory.
// Expectations follow AHB_MEM_CTRL_ERR_EN when it is defined.
module tb_ahb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr_pulses = 0;
  int n_collide = 0;

  always #5 clk = ~clk;

  ahb_mem_ctrl #(.MEM_AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      n_wr_pulses   <= n_wr_pulses + 1;
    end
    if (mem_read && mem_write) n_collide <= n_collide + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    hsel   = 1'b1;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] quiet_tab [0:2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFEF00D;
    reset  = 1'b1;
    hready = 1'b1;
    hwdata = 32'h0;
    idle_bus();
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    $display("txn: reset values");
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp",     32'(hresp),     32'd0);
    check_eq("rst_hrdata",    hrdata,         32'h0);
    check_eq("rst_mem_read",  32'(mem_read),  32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr),  32'd0);
    check_eq("rst_mem_wdata", mem_wdata,      32'h0);

    // Byte write 0xAB @0x010 interrupted by reset during RMW1.
    $display("txn: byte write 0xAB @0x010 aborted by reset in RMW1");
    cyc();
    addr_phase(2'd2, 1'b1, 32'h010, 3'd0);
    cyc();
    idle_bus();
    hwdata = 32'hABABABAB;
    @(negedge clk);
    check_eq("rmw1_rst_mem_read",  32'(mem_read),  32'd1);
    check_eq("rmw1_rst_hreadyout", 32'(hreadyout), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("async_rst_hreadyout", 32'(hreadyout), 32'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("post_rst_hresp",     32'(hresp),     32'd0);
    check_eq("post_rst_hrdata",    hrdata,         32'h0);
    cyc();
    @(negedge clk);
    check_eq("post_rst_no_write",  32'(n_wr_pulses), 32'd0);
    check_eq("post_rst_mem4",      mem[4],         32'h0);

    // Word write then back-to-back read of the same word.
    $display("txn: word write 0xDEADBEEF @0x004");
    cyc();
    addr_phase(2'd2, 1'b1, 32'h004, 3'd2);
    cyc();
    hwdata = 32'hDEADBEEF;
    addr_phase(2'd2, 1'b0, 32'h004, 3'd2);
    @(negedge clk);
    check_eq("wr_mem_write", 32'(mem_write), 32'd1);
    check_eq("wr_mem_wdata", mem_wdata,      32'hDEADBEEF);
    check_eq("wr_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("wr_mem_addr",  32'(mem_addr),  32'd1);
    $display("txn: word read @0x004");
    cyc();
    idle_bus();
    @(negedge clk);
    check_eq("rd1_hreadyout", 32'(hreadyout), 32'd0);
    check_eq("rd1_mem_read",  32'(mem_read),  32'd1);
    check_eq("rd1_mem_write", 32'(mem_write), 32'd0);
    cyc();
    @(negedge clk);
    check_eq("rd2_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rd2_hrdata",    hrdata,         32'hDEADBEEF);

    // Byte write 0x5A into lane 2 of word 1.
    $display("txn: byte write 0x5A @0x006");
    addr_phase(2'd2, 1'b1, 32'h006, 3'd0);
    cyc();
    idle_bus();
    hwdata = 32'h5A5A5A5A;
    @(negedge clk);
    check_eq("b_rmw1_mem_read",  32'(mem_read),  32'd1);
    check_eq("b_rmw1_hreadyout", 32'(hreadyout), 32'd0);
    check_eq("b_rmw1_mem_write", 32'(mem_write), 32'd0);
    check_eq("b_rmw1_mem_addr",  32'(mem_addr),  32'd1);
    cyc();
    hwdata = 32'h0;
    @(negedge clk);
    check_eq("b_rmw2_mem_write", 32'(mem_write), 32'd1);
    check_eq("b_rmw2_mem_wdata", mem_wdata,      32'hDE5ABEEF);
    check_eq("b_rmw2_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("b_rmw2_mem_read",  32'(mem_read),  32'd0);
    check_eq("hrdata_hold_wr",   hrdata,         32'hDEADBEEF);

    // Half write 0x1234 into the upper half of word 2, then read it back.
    $display("txn: half write 0x1234 @0x00A");
    addr_phase(2'd2, 1'b1, 32'h00A, 3'd1);
    cyc();
    idle_bus();
    hwdata = 32'h12341234;
    @(negedge clk);
    check_eq("h_rmw1_mem_addr", 32'(mem_addr), 32'd2);
    cyc();
    @(negedge clk);
    check_eq("h_rmw2_mem_wdata", mem_wdata, 32'h12340000);
    check_eq("mem1_after_byte",  mem[1],    32'hDE5ABEEF);
    $display("txn: word read @0x008");
    addr_phase(2'd2, 1'b0, 32'h008, 3'd2);
    cyc();
    idle_bus();
    cyc();
    @(negedge clk);
    check_eq("h_rd2_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("h_rd2_hrdata",    hrdata,         32'h12340000);

    // Misaligned word read @0x003.
    $display("txn: misaligned word read @0x003");
    addr_phase(2'd2, 1'b0, 32'h003, 3'd2);
    cyc();
    idle_bus();
    @(negedge clk);
`ifdef AHB_MEM_CTRL_ERR_EN
    check_eq("err1_hresp",     32'(hresp),     32'd1);
    check_eq("err1_hreadyout", 32'(hreadyout), 32'd0);
    check_eq("err1_mem_read",  32'(mem_read),  32'd0);
    cyc();
    @(negedge clk);
    check_eq("err2_hresp",     32'(hresp),     32'd1);
    check_eq("err2_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("err2_mem_read",  32'(mem_read),  32'd0);
    check_eq("err2_hrdata",    hrdata,         32'h12340000);
`else
    check_eq("mis_rd1_hreadyout", 32'(hreadyout), 32'd0);
    check_eq("mis_rd1_mem_read",  32'(mem_read),  32'd1);
    check_eq("mis_rd1_mem_addr",  32'(mem_addr),  32'd0);
    check_eq("mis_rd1_hresp",     32'(hresp),     32'd0);
    cyc();
    @(negedge clk);
    check_eq("mis_rd2_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("mis_rd2_hrdata",    hrdata,         32'hCAFEF00D);
    check_eq("mis_rd2_hresp",     32'(hresp),     32'd0);
`endif

    // hready low blocks acceptance.
    $display("txn: NONSEQ read with hready=0");
    cyc();
    addr_phase(2'd2, 1'b0, 32'h008, 3'd2);
    hready = 1'b0;
    cyc();
    hready = 1'b1;
    idle_bus();
    @(negedge clk);
    check_eq("hready0_mem_read",  32'(mem_read),  32'd0);
    check_eq("hready0_hreadyout", 32'(hreadyout), 32'd1);

    // {hsel, htrans}: BUSY selected, IDLE selected, NONSEQ unselected.
    quiet_tab[0] = 3'b1_01;
    quiet_tab[1] = 3'b1_00;
    quiet_tab[2] = 3'b0_10;
    for (int i = 0; i < 3; i++) begin
      $display("txn: quiet cycle hsel=%0d htrans=%0d", quiet_tab[i][2], quiet_tab[i][1:0]);
      cyc();
      addr_phase(quiet_tab[i][1:0], 1'b0, 32'h004, 3'd2);
      hsel = quiet_tab[i][2];
      cyc();
      idle_bus();
      @(negedge clk);
      check_eq("quiet_hreadyout", 32'(hreadyout), 32'd1);
      check_eq("quiet_hresp",     32'(hresp),     32'd0);
      check_eq("quiet_strobes",   32'({mem_read, mem_write}), 32'd0);
    end

    cyc();
    @(negedge clk);
    check_eq("total_write_pulses", 32'(n_wr_pulses), 32'd3);
    check_eq("read_write_overlap", 32'(n_collide),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
